instr_decoder: RTL and testbench
================================

# instr_decoder

Registered RV32I instruction decoder that produces the 5-bit `Upr_ALU` control code, operand selects, immediate and write-back/memory/branch controls consumed by the ALU and datapath. It sits between instruction fetch and the execute stage. It accepts one instruction word per valid/ready handshake and presents a decoded bundle one cycle later through a one-entry output register with backpressure. It also counts illegal encodings.

## Interface
- `ILL_CNT_W`, 16, width of the illegal-instruction counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: `instr` is valid.
- `in_ready` out 1: the decoder can accept `instr`.
- `instr` in 32: RV32I instruction word.
- `flush` in 1: synchronous kill of the held and incoming instruction.
- `out_valid` out 1: decoded bundle is valid.
- `out_ready` in 1: execute stage accepts the bundle.
- `Upr_ALU` out 5: ALU op code. ADD 00000, SUB 01000, SLL 00001, SLTS 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111, EQ 11000, NE 11001, LTS 11100, GES 11101, LTU 11110, GEU 11111.
- `src_a_sel` out 2: operand A select. 0 = rs1, 1 = PC, 2 = zero.
- `src_b_sel` out 2: operand B select. 0 = rs2, 1 = imm, 2 = constant 4.
- `imm` out 32: sign-extended immediate (I/S/B/U/J format).
- `rd`, `rs1`, `rs2` out 5 each: register fields.
- `rf_we` out 1: register write enable. Forced to 0 when `rd` = 0.
- `wb_sel` out 2: write-back select. 0 = ALU, 1 = memory, 2 = PC+4.
- `mem_req` out 1, `mem_we` out 1, `mem_size` out 3: memory access request, store flag, and funct3 passthrough.
- `branch`, `jal`, `jalr` out 1 each: control-flow type.
- `illegal` out 1: the current bundle is an illegal encoding.
- `ill_cnt` out ILL_CNT_W: number of illegal instructions accepted.

## Operation
- Decode is combinational from `instr`. The result is captured into the output register when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This gives full throughput of one instruction per cycle with no bubble.
- Opcode mapping:
  - OP (0110011): funct3/funct7 select ADD/SUB/SLL/SLTS/SLTU/XOR/SRL/SRA/OR/AND; `src_b_sel` = 0.
  - OP-IMM (0010011): same mapping, except SUB does not exist; SRAI is selected by instr[30]; `src_b_sel` = 1.
  - BRANCH (1100011): funct3 000/001/100/101/110/111 → EQ/NE/LTS/GES/LTU/GEU; `branch` = 1; `rf_we` = 0.
  - LOAD (0000011) and STORE (0100011): ADD with rs1 + imm; `mem_req` = 1; `wb_sel` = 1 for loads.
  - LUI (0110111): ADD with zero + imm.
  - AUIPC (0010111): ADD with PC + imm.
  - JAL (1101111): ADD with PC + imm; `wb_sel` = 2.
  - JALR (1100111): ADD with rs1 + imm; `wb_sel` = 2.
- Illegal encodings:
  - instr[1:0] ≠ 11, or an unlisted opcode.
  - OP with funct7 ∉ {0000000, 0100000}, or 0100000 with funct3 ∉ {000, 101}.
  - Shift-immediate with a bad funct7.
  - BRANCH funct3 010/011.
  - LOAD funct3 011/110/111.
  - STORE funct3 > 010.
  - JALR funct3 ≠ 000.
- An illegal bundle is still emitted with `illegal` = 1, `Upr_ALU` = ADD, and all enables (`rf_we`, `mem_req`, `mem_we`, `branch`, `jal`, `jalr`) = 0.
- `flush` has priority over everything:
  - The next cycle has `out_valid` = 0.
  - An instruction handshaken in the same cycle is discarded and not counted.
  - `in_ready` is unaffected.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible with `out_valid` = 1 after edge N.
- While `out_valid && !out_ready`, all outputs hold stable and `in_ready` = 0.
- Reset values: `out_valid` = 0 and `ill_cnt` = 0. All bundle outputs are 0, which gives `Upr_ALU` = ADD.
- `in_ready` = 1 during and after reset. Asserting reset mid-operation drops the held bundle immediately (asynchronous).
- `ill_cnt` increments on the edge that accepts an illegal instruction and saturates at all-ones. It is not decremented by a flush of an already-held bundle.

## Configuration
- `DECODER_ILL_CNT_EN` defined: the counter is implemented as described above.
- `DECODER_ILL_CNT_EN` undefined: no counter flops are built and `ill_cnt` is tied to 0. The `illegal` flag still operates.

## Test plan
- `add x3,x1,x2` (0x002081B3) → after 1 cycle: `Upr_ALU` = 00000, rd = 3, rs1 = 1, rs2 = 2, `src_b_sel` = 0, `rf_we` = 1, `wb_sel` = 0.
- `sra x3,x1,x2` (0x4020D1B3) → `Upr_ALU` = 01101. `addi x5,x0,-1` (0xFFF00293) → `Upr_ALU` = 00000, `imm` = 0xFFFFFFFF, `src_b_sel` = 1.
- `beq x1,x2,+8` (0x00208463) → `Upr_ALU` = 11000, `branch` = 1, `imm` = 0x00000008, `rf_we` = 0. The same word with funct3 = 110 → `Upr_ALU` = 11110.
- `instr` = 0x00000000 → `illegal` = 1, all enables 0, `ill_cnt` 0 → 1. Forcing the counter to all-ones and sending another illegal word keeps it at all-ones.
- Backpressure: hold `out_ready` = 0 for 3 cycles with `in_valid` = 1 → outputs frozen and `in_ready` = 0. When `out_ready` rises, the next instruction appears 1 cycle later with no loss or duplication.
- Assert `flush` together with `in_valid` → next cycle `out_valid` = 0 and `ill_cnt` unchanged. Pulse `rst_n` low mid-stream → `out_valid` = 0 asynchronously.

Source files
------------

// File: rtl/instr_decoder_if.sv
// instr_decoder_if: fetch-side handshake plus the decoded bundle handed to execute.
// master = surrounding pipeline (drives instr/flush/out_ready), slave = decoder.
interface instr_decoder_if #(
    parameter int ILL_CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instr;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [4:0]           Upr_ALU;
    logic [1:0]           src_a_sel;
    logic [1:0]           src_b_sel;
    logic [31:0]          imm;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic                 rf_we;
    logic [1:0]           wb_sel;
    logic                 mem_req;
    logic                 mem_we;
    logic [2:0]           mem_size;
    logic                 branch;
    logic                 jal;
    logic                 jalr;
    logic                 illegal;
    logic [ILL_CNT_W-1:0] ill_cnt;

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, Upr_ALU, src_a_sel, src_b_sel, imm,
               rd, rs1, rs2, rf_we, wb_sel, mem_req, mem_we, mem_size,
               branch, jal, jalr, illegal, ill_cnt
    );

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, Upr_ALU, src_a_sel, src_b_sel, imm,
               rd, rs1, rs2, rf_we, wb_sel, mem_req, mem_we, mem_size,
               branch, jal, jalr, illegal, ill_cnt
    );
endinterface

// File: rtl/instr_decoder.sv
// instr_decoder: registered RV32I decoder with a one-entry output register and
// valid/ready backpressure. Define DECODER_ILL_CNT_EN to build the saturating
// illegal-instruction counter; otherwise ill_cnt is tied to zero.
module instr_decoder #(
    parameter int ILL_CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_decoder_if.slave  bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] WB_ALU     = 2'd0;
    localparam logic [1:0] WB_MEM     = 2'd1;
    localparam logic [1:0] WB_PC4     = 2'd2;

    // instruction fields
    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign ins    = bus.instr;
    assign opcode = ins[6:0];
    assign funct3 = ins[14:12];
    assign funct7 = ins[31:25];

    // immediates for every format
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    // combinational decode results
    logic [4:0]  d_alu;
    logic [1:0]  d_src_a;
    logic [1:0]  d_src_b;
    logic [31:0] d_imm;
    logic        d_we;
    logic [1:0]  d_wb;
    logic        d_mem_req;
    logic        d_mem_we;
    logic        d_branch;
    logic        d_jal;
    logic        d_jalr;
    logic        d_ill;
    logic        d_rf_we;

    // opcode/funct decode into the control bundle, illegal words collapse to a safe ADD
    always_comb begin
        d_alu     = ALU_ADD;
        d_src_a   = SRC_A_RS1;
        d_src_b   = SRC_B_RS2;
        d_imm     = '0;
        d_we      = 1'b0;
        d_wb      = WB_ALU;
        d_mem_req = 1'b0;
        d_mem_we  = 1'b0;
        d_branch  = 1'b0;
        d_jal     = 1'b0;
        d_jalr    = 1'b0;
        d_ill     = 1'b0;

        unique case (opcode)
            OPC_OP: begin
                d_we = 1'b1;
                if (funct7 == F7_ZERO) begin
                    d_alu = {2'b00, funct3};
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    d_alu = {2'b01, funct3};
                end else begin
                    d_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                d_we    = 1'b1;
                d_src_b = SRC_B_IMM;
                d_imm   = imm_i;
                d_alu   = {2'b00, funct3};
                if (funct3 == 3'b001) begin
                    if (funct7 != F7_ZERO) d_ill = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       d_alu[3] = 1'b1;
                    else if (funct7 != F7_ZERO) d_ill    = 1'b1;
                end
            end
            OPC_BRANCH: begin
                d_branch = 1'b1;
                d_imm    = imm_b;
                d_alu    = {2'b11, funct3};
                if (funct3 == 3'b010 || funct3 == 3'b011) d_ill = 1'b1;
            end
            OPC_LOAD: begin
                d_we      = 1'b1;
                d_src_b   = SRC_B_IMM;
                d_imm     = imm_i;
                d_mem_req = 1'b1;
                d_wb      = WB_MEM;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) d_ill = 1'b1;
            end
            OPC_STORE: begin
                d_src_b   = SRC_B_IMM;
                d_imm     = imm_s;
                d_mem_req = 1'b1;
                d_mem_we  = 1'b1;
                if (funct3 > 3'b010) d_ill = 1'b1;
            end
            OPC_LUI: begin
                d_we    = 1'b1;
                d_src_a = SRC_A_ZERO;
                d_src_b = SRC_B_IMM;
                d_imm   = imm_u;
            end
            OPC_AUIPC: begin
                d_we    = 1'b1;
                d_src_a = SRC_A_PC;
                d_src_b = SRC_B_IMM;
                d_imm   = imm_u;
            end
            OPC_JAL: begin
                d_we    = 1'b1;
                d_src_a = SRC_A_PC;
                d_src_b = SRC_B_IMM;
                d_imm   = imm_j;
                d_wb    = WB_PC4;
                d_jal   = 1'b1;
            end
            OPC_JALR: begin
                d_we    = 1'b1;
                d_src_b = SRC_B_IMM;
                d_imm   = imm_i;
                d_wb    = WB_PC4;
                d_jalr  = 1'b1;
                if (funct3 != 3'b000) d_ill = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase

        // An illegal word still produces a bundle, but one that cannot change state.
        if (d_ill) begin
            d_alu     = ALU_ADD;
            d_src_a   = SRC_A_RS1;
            d_src_b   = SRC_B_RS2;
            d_imm     = '0;
            d_we      = 1'b0;
            d_wb      = WB_ALU;
            d_mem_req = 1'b0;
            d_mem_we  = 1'b0;
            d_branch  = 1'b0;
            d_jal     = 1'b0;
            d_jalr    = 1'b0;
        end
    end

    assign d_rf_we = d_we && (ins[11:7] != 5'd0);

    // handshake
    logic out_valid_q;
    logic accept;
    logic capture;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign capture      = accept && !bus.flush;

    // output-register occupancy; flush wins over a same-cycle accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // registered bundle
    logic [4:0]  alu_q;
    logic [1:0]  src_a_q;
    logic [1:0]  src_b_q;
    logic [31:0] imm_q;
    logic [4:0]  rd_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic        rf_we_q;
    logic [1:0]  wb_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [2:0]  mem_size_q;
    logic        branch_q;
    logic        jal_q;
    logic        jalr_q;
    logic        ill_q;

    // capture the decoded bundle on every non-flushed handshake, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q      <= '0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rf_we_q    <= 1'b0;
            wb_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_size_q <= '0;
            branch_q   <= 1'b0;
            jal_q      <= 1'b0;
            jalr_q     <= 1'b0;
            ill_q      <= 1'b0;
        end else if (capture) begin
            alu_q      <= d_alu;
            src_a_q    <= d_src_a;
            src_b_q    <= d_src_b;
            imm_q      <= d_imm;
            rd_q       <= ins[11:7];
            rs1_q      <= ins[19:15];
            rs2_q      <= ins[24:20];
            rf_we_q    <= d_rf_we;
            wb_q       <= d_wb;
            mem_req_q  <= d_mem_req;
            mem_we_q   <= d_mem_we;
            mem_size_q <= funct3;
            branch_q   <= d_branch;
            jal_q      <= d_jal;
            jalr_q     <= d_jalr;
            ill_q      <= d_ill;
        end
    end

`ifdef DECODER_ILL_CNT_EN
    logic [ILL_CNT_W-1:0] ill_cnt_q;

    // saturating count of accepted (non-flushed) illegal words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt_q <= '0;
        end else if (capture && d_ill && ill_cnt_q != '1) begin
            ill_cnt_q <= ill_cnt_q + 1'b1;
        end
    end

    assign bus.ill_cnt = ill_cnt_q;
`else
    assign bus.ill_cnt = '0;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.Upr_ALU   = alu_q;
    assign bus.src_a_sel = src_a_q;
    assign bus.src_b_sel = src_b_q;
    assign bus.imm       = imm_q;
    assign bus.rd        = rd_q;
    assign bus.rs1       = rs1_q;
    assign bus.rs2       = rs2_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.wb_sel    = wb_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.branch    = branch_q;
    assign bus.jal       = jal_q;
    assign bus.jalr      = jalr_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: scoreboard bench. The driver pushes reference-model bundles
// for every accepted word; an independent monitor pops them on each transfer.
module tb_instr_decoder;
    localparam int CW = 4;
`ifdef DECODER_ILL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_decoder_if #(.ILL_CNT_W(CW)) dif ();
    instr_decoder #(.ILL_CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(dif));

    typedef struct packed {
        logic [4:0]  alu;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        we;
        logic [1:0]  wb;
        logic        mreq;
        logic        mwe;
        logic [2:0]  msz;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        ill;
    } bundle_t;

    bundle_t     exp_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned model_cnt = 0;
    bit          mon_en = 1'b0;

    // reference decoder: immediates built arithmetically from the instruction fields
    function automatic bundle_t ref_decode(input logic [31:0] w);
        bundle_t     e;
        int unsigned f3, f7;
        int          sgn, ii, si, bi, ji;
        bit          ok, writes;
        f3  = int'(w[14:12]);
        f7  = int'(w[31:25]);
        sgn = $signed(w) >>> 31;
        ii  = $signed(w) >>> 20;
        si  = (($signed(w) >>> 25) * 32) + int'(w[11:7]);
        bi  = sgn * 4096 + (int'(w[7]) << 11) + (int'(w[30:25]) << 5) + (int'(w[11:8]) << 1);
        ji  = sgn * (1 << 20) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11) + (int'(w[30:21]) << 1);
        e = '0;
        e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.msz = w[14:12];
        ok = 1'b1; writes = 1'b0;
        case (w[6:0])
            7'h33: begin
                ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                e.alu = 5'(f3 + ((f7 == 32) ? 8 : 0)); writes = 1'b1;
            end
            7'h13: begin
                ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
                e.alu = 5'(f3 + ((f3 == 5 && f7 == 32) ? 8 : 0));
                e.b = 2'd1; e.imm = ii; writes = 1'b1;
            end
            7'h63: begin
                ok = (f3 != 2 && f3 != 3); e.alu = 5'(24 + f3); e.br = 1'b1; e.imm = bi;
            end
            7'h03: begin
                ok = f3 inside {0, 1, 2, 4, 5};
                e.b = 2'd1; e.imm = ii; e.mreq = 1'b1; e.wb = 2'd1; writes = 1'b1;
            end
            7'h23: begin
                ok = (f3 <= 2); e.b = 2'd1; e.imm = si; e.mreq = 1'b1; e.mwe = 1'b1;
            end
            7'h37: begin e.a = 2'd2; e.b = 2'd1; e.imm = w & 32'hFFFFF000; writes = 1'b1; end
            7'h17: begin e.a = 2'd1; e.b = 2'd1; e.imm = w & 32'hFFFFF000; writes = 1'b1; end
            7'h6f: begin
                e.a = 2'd1; e.b = 2'd1; e.imm = ji; e.wb = 2'd2; e.jal = 1'b1; writes = 1'b1;
            end
            7'h67: begin
                ok = (f3 == 0); e.b = 2'd1; e.imm = ii; e.wb = 2'd2; e.jalr = 1'b1; writes = 1'b1;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e = '0;
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.msz = w[14:12];
            e.ill = 1'b1;
            writes = 1'b0;
        end
        e.we = writes && (w[11:7] != 5'd0);
        return e;
    endfunction

    function automatic bundle_t sample();
        bundle_t s;
        s.alu = dif.Upr_ALU; s.a = dif.src_a_sel; s.b = dif.src_b_sel; s.imm = dif.imm;
        s.rd = dif.rd; s.rs1 = dif.rs1; s.rs2 = dif.rs2; s.we = dif.rf_we; s.wb = dif.wb_sel;
        s.mreq = dif.mem_req; s.mwe = dif.mem_we; s.msz = dif.mem_size; s.br = dif.branch;
        s.jal = dif.jal; s.jalr = dif.jalr; s.ill = dif.illegal;
        return s;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, expv, $time);
        end
    endtask

    // driver: one cycle of stimulus; model decides acceptance from its own occupancy
    task automatic step(input bit v, input logic [31:0] w, input bit f, input bit r);
        bit held, acc;
        bundle_t e;
        @(negedge clk);
        dif.in_valid = v; dif.instr = w; dif.flush = f; dif.out_ready = r;
        held = (exp_q.size() != 0);
        acc  = v && (!held || r);
        #2;
        if (f) begin
            if (held && !r) exp_q.delete(0);
        end else if (acc) begin
            e = ref_decode(w);
            exp_q.push_back(e);
            if (e.ill && model_cnt < (2 ** CW - 1)) model_cnt++;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67};
        logic [31:0] w;
        int unsigned k;
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) w[6:0] = ops[k];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    // monitor: occupancy, ready, counter and bundle checks, decoupled from the driver
    bit      ev;
    bit      stall_prev = 1'b0;
    bundle_t prev_b;
    bundle_t cur;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && rst_n) begin
                ev  = (exp_q.size() != 0);
                cur = sample();
                chk("out_valid", dif.out_valid, ev);
                chk("in_ready", dif.in_ready, !ev || dif.out_ready);
                chk("ill_cnt", dif.ill_cnt, CNT_EN ? model_cnt : 0);
                if (stall_prev && dif.out_valid) chk("stall_hold", cur, prev_b);
                if (dif.out_valid && dif.out_ready && ev) chk("bundle", cur, exp_q.pop_front());
                stall_prev = dif.out_valid && !dif.out_ready && !dif.flush;
                prev_b     = cur;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic mid_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        dif.in_valid = 1'b0;
        #1;
        chk("async_rst_valid", dif.out_valid, 1'b0);
        chk("async_rst_ready", dif.in_ready, 1'b1);
        chk("async_rst_cnt", dif.ill_cnt, 0);
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] dir[6] = '{32'h002081B3, 32'h4020D1B3, 32'hFFF00293,
                                32'h00208463, 32'h0020E463, 32'h00000000};
        dif.in_valid = 1'b0; dif.instr = '0; dif.flush = 1'b0; dif.out_ready = 1'b0;
        #2;
        chk("rst_out_valid", dif.out_valid, 1'b0);
        chk("rst_in_ready", dif.in_ready, 1'b1);
        chk("rst_ill_cnt", dif.ill_cnt, 0);
        chk("rst_bundle", sample(), '0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        mon_en = 1'b1;

        foreach (dir[i]) step(1'b1, dir[i], 1'b0, 1'b1);

        // backpressure: held bundle frozen for three cycles, then released
        step(1'b1, 32'hFFF00293, 1'b0, 1'b1);
        repeat (3) step(1'b1, 32'h002081B3, 1'b0, 1'b0);
        step(1'b1, 32'h002081B3, 1'b0, 1'b1);
        step(1'b1, 32'h4020D1B3, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // flush with an incoming illegal word, and flush of a stalled bundle
        step(1'b1, 32'h00000000, 1'b1, 1'b1);
        step(1'b1, 32'h00208463, 1'b0, 1'b0);
        step(1'b1, 32'h00000000, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // saturate the counter
        repeat (20) step(1'b1, 32'h00000000, 1'b0, 1'b1);
        step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);

        repeat (1500) step($urandom_range(0, 3) != 0, rand_instr(),
                           $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        mid_reset();
        repeat (500) step($urandom_range(0, 3) != 0, rand_instr(),
                          $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);

        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
